gcd_job_arbiter: RTL and testbench
==================================

Name: gcd_job_arbiter

Overview:
- Shares one GCD microprocessor core between N requesters.
- Round-robin arbitration picks a requester; the block then runs the core's full job sequence: reset pulse, testStart pulse, X load, Y load, wait for Halt, capture dataOut.
- The result goes back to the granted requester as a one-cycle done pulse.
- Sits between the requester fabric and the single microprocessor instance, and owns all of the core's control inputs.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand/result width; must match core data_in/dataOut.
- LOAD_CYCLES, 4, cycles X is held on core data_in before switching to Y.
- TIMEOUT, 1023, max cycles to wait for core Halt after Y is applied.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester job request; held high until req_ack.
- req_x  in  N*W  flattened X operands, requester i at [i*W +: W].
- req_y  in  N*W  flattened Y operands, same packing.
- req_ack  out  N  one-hot, one-cycle pulse when the job is accepted.
- rsp_done  out  N  one-hot, one-cycle pulse when the result is valid.
- rsp_result  out  W  GCD result; valid in the rsp_done cycle, then held.
- rsp_err  out  1  qualifies rsp_done: 1 = zero operand or timeout.
- busy  out  1  high from accept through rsp_done.
- mp_data_in  out  W  to core data_in.
- mp_Enter  out  1  to core Enter.
- mp_Reset  out  1  to core Reset.
- mp_testStart  out  1  to core testStart.
- mp_dataOut  in  W  from core dataOut.
- mp_Halt  in  1  from core Halt.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ack=0, rsp_done=0, rsp_result=0, rsp_err=0, busy=0.
  - mp_Reset=1 (core held in reset), mp_testStart=0, mp_Enter=1, mp_data_in=0.
- mp_Enter is held constant 1 in all states.
- IDLE:
  - mp_Reset=1.
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_ack for the winner; latch X, Y and winner index; busy=1.
  - Set rr_ptr = winner+1 mod N. Go to CHECK.
- CHECK (1 cycle):
  - If X==0 or Y==0: go to RESP with err=1, result=0. The core is never released from reset; the subtractive GCD would not terminate.
  - Otherwise go to MP_RST.
- MP_RST (1 cycle): mp_Reset=1, mp_testStart=1. Go to START.
- START (1 cycle): mp_Reset=0, mp_testStart=1. Go to LOAD_X.
- LOAD_X (exactly LOAD_CYCLES cycles): mp_testStart=0, mp_data_in=X. Go to LOAD_Y.
- LOAD_Y:
  - mp_data_in=Y. A TIMEOUT counter starts at 0 on entry.
  - mp_Halt==1 sampled: go to CAPTURE.
  - Counter reaches TIMEOUT: go to RESP with err=1, result=0.
- CAPTURE (1 cycle): result <= mp_dataOut, err <= 0. Go to RESP.
- RESP (1 cycle):
  - Pulse rsp_done[winner]; drive rsp_result and rsp_err; busy stays 1 this cycle.
  - Go to IDLE, which reasserts mp_Reset.
- Back-to-back jobs: the next acceptance happens in the cycle after RESP at the earliest. There is no pipelining; one job in flight.
- Latency (nonzero operands): ack to done = 4 + LOAD_CYCLES + (cycles to Halt).
- Simultaneous requests: only one req_ack per cycle. Losers keep req_valid high and are never starved; each waits at most N-1 jobs.
- Requester deasserts req_valid before ack: nothing is recorded. After ack, deassertion has no effect (operands already latched).
- mp_Halt high while not in LOAD_Y: ignored.
- Reset mid-job: returns to IDLE next cycle, no rsp_done, job discarded, core forced into reset.
- All counters are sized with $clog2 of their parameter; no wrap is possible inside a state.

Decomposition:
- Shared package gcd_pkg:
  - State enum: IDLE, CHECK, MP_RST, START, LOAD_X, LOAD_Y, CAPTURE, RESP.
  - Defaults for W and LOAD_CYCLES, shared with the microprocessor and its bench.
- One sub-module: rr_arbiter (N-bit request, rr_ptr in, one-hot grant and index out; combinational priority rotate).
- FSM and counters stay in gcd_job_arbiter.

Test Plan:
- Single job: requester 0 with X=12, Y=18 → one req_ack[0]; mp_data_in=12 for 4 cycles then 18; after Halt, rsp_done[0] with result=6, err=0; busy low next cycle.
- Round-robin: all 4 req_valid high with distinct pairs (e.g., (7,15),(9,6),(25,10),(8,8)) → acks in order 0,1,2,3; results 1,3,5,8; a repeat burst starts at 0 again.
- Zero operand: requester 2 with X=0, Y=20 → rsp_done[2] with err=1, result=0; mp_Reset never deasserted during the job.
- Timeout: TIMEOUT=20 and stubbed core holding Halt=0 → rsp_done with err=1 exactly 20 cycles after entering LOAD_Y; next job proceeds normally.
- Reset mid-job: assert Reset during LOAD_Y → all outputs at reset values next cycle, no rsp_done; pending requester is re-acked after Reset drops.
- Regression: 20 random nonzero (X,Y) pairs across random requesters, checked against a reference GCD model → all pass, no lost or duplicated acks/dones.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and the job arbiter in front of it.
// Operand width and X-load hold time are the core's defaults.
package gcd_pkg;

    localparam int GCD_W           = 8;
    localparam int GCD_LOAD_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MP_RST,
        START,
        LOAD_X,
        LOAD_Y,
        CAPTURE,
        RESP
    } job_state_e;

endpackage

// File: rtl/gcd_job_arbiter_rr.sv
// Round-robin priority picker: first set request at or above the
// pointer, wrapping, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one GCD core among N requesters: picks a job round-robin,
// sequences the core through reset/start/load/halt, returns the result.
module gcd_job_arbiter
    import gcd_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = GCD_W,
    parameter int LOAD_CYCLES = GCD_LOAD_CYCLES,
    parameter int TIMEOUT     = 1023
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req_valid,
    input  logic [N*W-1:0] i_req_x,
    input  logic [N*W-1:0] i_req_y,
    output logic [N-1:0]   o_req_ack,
    output logic [N-1:0]   o_rsp_done,
    output logic [W-1:0]   o_rsp_result,
    output logic           o_rsp_err,
    output logic           o_busy,
    output logic [W-1:0]   o_mp_data_in,
    output logic           o_mp_Enter,
    output logic           o_mp_Reset,
    output logic           o_mp_testStart,
    input  logic [W-1:0]   i_mp_dataOut,
    input  logic           i_mp_Halt
);

    localparam int IW = $clog2(N);
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    job_state_e    r_state, w_next;
    logic [IW-1:0] r_ptr, r_idx, w_idx;
    logic [N-1:0]  w_grant;
    logic          w_any, w_accept, w_zero_op;
    logic          w_load_last, w_timeout;
    logic [W-1:0]  r_x, r_y, r_result;
    logic          r_err;
    logic [LW-1:0] r_load_cnt;
    logic [TW-1:0] r_to_cnt;

    rr_arbiter #(.N(N)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept    = (r_state == IDLE) && w_any && !i_rst;
    assign w_zero_op   = (r_x == '0) || (r_y == '0);
    assign w_load_last = r_load_cnt == LW'(LOAD_CYCLES - 1);
    assign w_timeout   = r_to_cnt == TW'(TIMEOUT - 1);

    assign o_busy       = (r_state != IDLE) || w_accept;
    assign o_mp_Enter   = 1'b1;
    assign o_rsp_result = r_result;
    assign o_rsp_err    = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_load_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= w_idx;
                r_x   <= i_req_x[w_idx*W +: W];
                r_y   <= i_req_y[w_idx*W +: W];
                r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
            end
            r_load_cnt <= (r_state == LOAD_X) ? r_load_cnt + 1'b1 : '0;
            r_to_cnt   <= (r_state == LOAD_Y) ? r_to_cnt + 1'b1 : '0;
            if (r_state == CHECK && w_zero_op) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
            if (r_state == LOAD_Y && !i_mp_Halt && w_timeout) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
            if (r_state == CAPTURE) begin
                r_result <= i_mp_dataOut;
                r_err    <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        o_req_ack      = '0;
        o_rsp_done     = '0;
        o_mp_Reset     = 1'b1;
        o_mp_testStart = 1'b0;
        o_mp_data_in   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    o_req_ack = w_grant;
                    w_next    = CHECK;
                end
            end
            CHECK:   w_next = w_zero_op ? RESP : MP_RST;
            MP_RST: begin
                o_mp_testStart = 1'b1;
                w_next         = START;
            end
            START: begin
                o_mp_Reset     = 1'b0;
                o_mp_testStart = 1'b1;
                w_next         = LOAD_X;
            end
            LOAD_X: begin
                o_mp_Reset   = 1'b0;
                o_mp_data_in = r_x;
                if (w_load_last) w_next = LOAD_Y;
            end
            LOAD_Y: begin
                o_mp_Reset   = 1'b0;
                o_mp_data_in = r_y;
                if (i_mp_Halt)      w_next = CAPTURE;
                else if (w_timeout) w_next = RESP;
            end
            CAPTURE: begin
                o_mp_Reset = 1'b0;
                w_next     = RESP;
            end
            RESP: begin
                // a zero-operand job never lets the core out of reset
                o_mp_Reset        = w_zero_op;
                o_rsp_done[r_idx] = 1'b1;
                w_next            = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed bench for gcd_job_arbiter with a behavioural GCD core stub.
module tb_gcd_job_arbiter;
    import gcd_pkg::*;

    localparam int N  = 4;
    localparam int W  = GCD_W;
    localparam int LC = GCD_LOAD_CYCLES;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x, req_y;
    logic [N-1:0]   req_ack, rsp_done;
    logic [W-1:0]   rsp_result;
    logic           rsp_err, busy;
    logic [W-1:0]   mp_data_in, mp_dataOut;
    logic           mp_Enter, mp_Reset, mp_testStart, mp_Halt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gcd_job_arbiter #(.N(N), .W(W), .LOAD_CYCLES(LC), .TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_x        (req_x),
        .i_req_y        (req_y),
        .o_req_ack      (req_ack),
        .o_rsp_done     (rsp_done),
        .o_rsp_result   (rsp_result),
        .o_rsp_err      (rsp_err),
        .o_busy         (busy),
        .o_mp_data_in   (mp_data_in),
        .o_mp_Enter     (mp_Enter),
        .o_mp_Reset     (mp_Reset),
        .o_mp_testStart (mp_testStart),
        .i_mp_dataOut   (mp_dataOut),
        .i_mp_Halt      (mp_Halt)
    );

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a_in,
                                             input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // core stub: latches X on the first load cycle, Y on the first Y
    // cycle, raises Halt three cycles later unless stalled
    int           s_cnt;
    logic [W-1:0] s_x, s_y;
    logic         stall;

    always @(posedge clk) begin
        if (mp_Reset) begin
            s_cnt      <= 0;
            mp_Halt    <= 1'b0;
            mp_dataOut <= '0;
        end else if (mp_testStart) begin
            s_cnt <= 0;
        end else begin
            s_cnt <= s_cnt + 1;
            if (s_cnt == 0)  s_x <= mp_data_in;
            if (s_cnt == LC) s_y <= mp_data_in;
            if (s_cnt == LC + 3 && !stall) begin
                mp_Halt    <= 1'b1;
                mp_dataOut <= gcd_ref(s_x, s_y);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int i, input logic [W-1:0] x,
                           input logic [W-1:0] y,
                           output logic [N-1:0] ack_seen,
                           output logic [N-1:0] done_seen,
                           output logic [W-1:0] res, output logic err,
                           output int cyc, output logic rst_low);
        int k;
        @(negedge clk);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_valid[i]    = 1'b1;
        #1;
        k = 0;
        while (req_ack == 0 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        ack_seen = req_ack;
        @(negedge clk);
        req_valid[i] = 1'b0;
        #1;
        cyc     = 1;
        rst_low = 1'b0;
        while (rsp_done == 0 && cyc < 200) begin
            if (!mp_Reset) rst_low = 1'b1;
            @(negedge clk); #1; cyc++;
        end
        done_seen = rsp_done;
        res       = rsp_result;
        err       = rsp_err;
    endtask

    task automatic job_chk(input string tag, input int i,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_res, input logic exp_err,
                           input int exp_cyc, output logic rst_low);
        logic [N-1:0] a, d;
        logic [W-1:0] r;
        logic         e;
        int           c;
        run_job(i, x, y, a, d, r, e, c, rst_low);
        chk({tag, "_ack"}, a, 1 << i);
        chk({tag, "_done"}, d, 1 << i);
        chk({tag, "_res"}, r, exp_res);
        chk({tag, "_err"}, e, exp_err);
        if (exp_cyc >= 0) chk({tag, "_lat"}, c, exp_cyc);
    endtask

    logic [W-1:0] bx[N], by[N], br[N];

    task automatic burst(input string tag, input int start);
        int           na, nd, cyc;
        int           ack_ord[N], done_ord[N];
        logic [W-1:0] dres[N];
        logic         derr[N];
        logic [N-1:0] clr;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = bx[i];
            req_y[i*W +: W] = by[i];
        end
        req_valid = '1;
        #1;
        na  = 0;
        nd  = 0;
        cyc = 0;
        clr = '0;
        while (nd < N && cyc < 400) begin
            for (int j = 0; j < N; j++) begin
                if (req_ack[j]) begin
                    if (na < N) ack_ord[na] = j;
                    na++;
                end
                if (rsp_done[j] && nd < N) begin
                    done_ord[nd] = j;
                    dres[nd]     = rsp_result;
                    derr[nd]     = rsp_err;
                    nd++;
                end
            end
            clr = clr | req_ack;
            @(negedge clk);
            req_valid = req_valid & ~clr;
            clr       = '0;
            #1;
            cyc++;
        end
        chk({tag, "_nack"}, na, N);
        chk({tag, "_ndone"}, nd, N);
        for (int k = 0; k < N; k++) begin
            if (k < na && k < nd) begin
                chk({tag, "_ack_order"}, ack_ord[k], (start + k) % N);
                chk({tag, "_done_order"}, done_ord[k], (start + k) % N);
                chk({tag, "_res"}, dres[k], br[(start + k) % N]);
                chk({tag, "_err"}, derr[k], 0);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         rl, seen_done;
        int           cyc;
        logic [W-1:0] x, y;
        int           ri;

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        stall     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", req_ack, 0);
        chk("rst_done", rsp_done, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mp_reset", mp_Reset, 1);
        chk("rst_mp_enter", mp_Enter, 1);
        chk("rst_mp_start", mp_testStart, 0);
        chk("rst_mp_data", mp_data_in, 0);
        @(negedge clk);
        rst = 1'b0;

        bx = '{8'd7, 8'd9, 8'd25, 8'd8};
        by = '{8'd15, 8'd6, 8'd10, 8'd8};
        br = '{8'd1, 8'd3, 8'd5, 8'd8};
        burst("rr1", 0);

        bx = '{8'd12, 8'd14, 8'd100, 8'd17};
        by = '{8'd8, 8'd21, 8'd75, 8'd5};
        br = '{8'd4, 8'd7, 8'd25, 8'd1};
        burst("rr2", 0);

        @(negedge clk);
        req_x[0 +: W] = 8'd12;
        req_y[0 +: W] = 8'd18;
        req_valid     = 4'b0001;
        #1;
        chk("sj_ack", req_ack, 4'b0001);
        chk("sj_busy", busy, 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("sj_ack_pulse", req_ack, 0);
        @(negedge clk); #1;
        chk("sj_mprst_reset", mp_Reset, 1);
        chk("sj_mprst_start", mp_testStart, 1);
        @(negedge clk); #1;
        chk("sj_start_reset", mp_Reset, 0);
        chk("sj_start_start", mp_testStart, 1);
        for (int k = 0; k < LC; k++) begin
            @(negedge clk); #1;
            chk("sj_data_x", mp_data_in, 12);
            chk("sj_start_low", mp_testStart, 0);
        end
        @(negedge clk); #1;
        chk("sj_data_y", mp_data_in, 18);
        cyc = 8;
        while (rsp_done == 0 && cyc < 100) begin
            @(negedge clk); #1; cyc++;
        end
        chk("sj_done", rsp_done, 4'b0001);
        chk("sj_res", rsp_result, 6);
        chk("sj_err", rsp_err, 0);
        chk("sj_busy_resp", busy, 1);
        chk("sj_lat", cyc, 14);
        @(negedge clk); #1;
        chk("sj_busy_after", busy, 0);
        chk("sj_done_pulse", rsp_done, 0);
        chk("sj_res_hold", rsp_result, 6);
        chk("sj_idle_reset", mp_Reset, 1);

        job_chk("zero", 2, 8'd0, 8'd20, 8'd0, 1'b1, 2, rl);
        chk("zero_core_held", rl, 0);

        stall = 1'b1;
        job_chk("tmo", 1, 8'd9, 8'd12, 8'd0, 1'b1, 8 + TO, rl);
        stall = 1'b0;
        job_chk("post_tmo", 3, 8'd9, 8'd12, 8'd3, 1'b0, 14, rl);

        @(negedge clk);
        req_x[3*W +: W] = 8'd20;
        req_y[3*W +: W] = 8'd30;
        req_valid       = 4'b1000;
        #1;
        chk("mr_ack", req_ack, 4'b1000);
        @(negedge clk);
        req_valid       = 4'b0010;
        req_x[1*W +: W] = 8'd21;
        req_y[1*W +: W] = 8'd14;
        #1;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (rsp_done != 0) seen_done = 1'b1;
        end
        chk("mr_in_load_y", mp_data_in, 30);
        rst = 1'b1;
        @(negedge clk); #1;
        if (rsp_done != 0) seen_done = 1'b1;
        chk("mr_no_done", seen_done, 0);
        chk("mr_ack_rst", req_ack, 0);
        chk("mr_busy", busy, 0);
        chk("mr_result", rsp_result, 0);
        chk("mr_err", rsp_err, 0);
        chk("mr_mp_reset", mp_Reset, 1);
        chk("mr_mp_start", mp_testStart, 0);
        chk("mr_mp_data", mp_data_in, 0);
        chk("mr_mp_enter", mp_Enter, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_reack", req_ack, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        cyc = 1;
        while (rsp_done == 0 && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        chk("mr_done", rsp_done, 4'b0010);
        chk("mr_res", rsp_result, 7);
        chk("mr_lat", cyc, 14);

        for (int n = 0; n < 20; n++) begin
            ri = int'($urandom_range(0, N - 1));
            x  = W'($urandom_range(1, 255));
            y  = W'($urandom_range(1, 255));
            job_chk("rand", ri, x, y, gcd_ref(x, y), 1'b0, 14, rl);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
